// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline.
// It handles load-use bubbles, redirect flushes, memory freezes, the halt drain and a stall counter.
module hazard_ctrl #(
    parameter int LU_BUBBLES   = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_to_reg,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_rt,
    input  logic             ex_halt,
    input  logic             redirect,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, LU_STALL, DRAIN, HALTED} state_t;

    // The first bubble is issued from RUN, so LU_STALL only counts the remaining ones.
    localparam logic [2:0]       BCNT_INIT = (LU_BUBBLES > 1) ? 3'(LU_BUBBLES - 2) : 3'd0;
    localparam logic [3:0]       DCNT_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t     state;
    logic [2:0] bcnt;
    logic [3:0] dcnt;
    logic       load_use;

    always_comb begin
        load_use = ex_mem_to_reg && ex_reg_write && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        case (state)
            RUN: begin
                if (ex_halt) begin
                    pc_write     = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (redirect) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_write = 1'b0;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            LU_STALL: begin
                if (redirect) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_write = 1'b0;
                end else begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            DRAIN: begin
                pc_write     = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_write = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            bcnt        <= 3'd0;
            dcnt        <= 4'd0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            if (!pc_write && (state != HALTED) && (stall_count != CNT_MAX))
                stall_count <= stall_count + 1'b1;
            case (state)
                RUN: begin
                    if (ex_halt) begin
                        state <= DRAIN;
                        dcnt  <= DCNT_INIT;
                    end else if (!redirect && !mem_busy && load_use && (LU_BUBBLES > 1)) begin
                        state <= LU_STALL;
                        bcnt  <= BCNT_INIT;
                    end
                end
                LU_STALL: begin
                    if (redirect) begin
                        state <= RUN;
                    end else if (!mem_busy) begin
                        if (bcnt == 3'd0) state <= RUN;
                        else              bcnt  <= bcnt - 3'd1;
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        if (dcnt == 4'd0) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            dcnt <= dcnt - 4'd1;
                        end
                    end
                end
                HALTED: ;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 load-use bubbles, 16- and 4-bit counters)
// share one input stream and are compared every cycle against a behavioural model.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_to_reg, ex_reg_write, ex_halt, redirect, mem_busy;

    logic        o_pc[2], o_ifid[2], o_flush[2], o_idex[2], o_bub[2], o_halted[2];
    logic [15:0] sc_a;
    logic [3:0]  sc_b;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl #(.LU_BUBBLES(1), .DRAIN_CYCLES(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rt(ex_rt),
        .ex_halt(ex_halt), .redirect(redirect), .mem_busy(mem_busy),
        .pc_write(o_pc[0]), .if_id_write(o_ifid[0]), .if_id_flush(o_flush[0]),
        .id_ex_write(o_idex[0]), .id_ex_bubble(o_bub[0]), .halted(o_halted[0]),
        .stall_count(sc_a)
    );

    hazard_ctrl #(.LU_BUBBLES(3), .DRAIN_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rt(ex_rt),
        .ex_halt(ex_halt), .redirect(redirect), .mem_busy(mem_busy),
        .pc_write(o_pc[1]), .if_id_write(o_ifid[1]), .if_id_flush(o_flush[1]),
        .id_ex_write(o_idex[1]), .id_ex_bubble(o_bub[1]), .halted(o_halted[1]),
        .stall_count(sc_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: bubbles still owed, drain cycles left, halted flag, stall count
    localparam int DRAIN_N = 3;
    int lu_n[2] = '{1, 3};
    int cmax[2] = '{65535, 15};
    int owed[2];
    int dleft[2];
    bit draining[2];
    bit hlt[2];
    int cnt[2];
    bit e_pc[2], e_ifid[2], e_flush[2], e_idex[2], e_bub[2];

    function automatic bit hazard();
        return ex_mem_to_reg && ex_reg_write && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    task automatic set_exp(input int i, input bit pc, input bit ifid, input bit fl,
                           input bit idex, input bit bub);
        e_pc[i] = pc; e_ifid[i] = ifid; e_flush[i] = fl; e_idex[i] = idex; e_bub[i] = bub;
    endtask

    task automatic model_outputs();
        for (int i = 0; i < 2; i++) begin
            if (hlt[i])                   set_exp(i, 0, 0, 0, 0, 0);
            else if (draining[i])         set_exp(i, 0, 1, 1, 1, 1);
            else if (owed[i] > 0) begin
                if (redirect)             set_exp(i, 1, 1, 1, 1, 1);
                else if (mem_busy)        set_exp(i, 0, 0, 0, 0, 0);
                else                      set_exp(i, 0, 0, 0, 1, 1);
            end else begin
                if (ex_halt)              set_exp(i, 0, 1, 1, 1, 1);
                else if (redirect)        set_exp(i, 1, 1, 1, 1, 1);
                else if (mem_busy)        set_exp(i, 0, 0, 0, 0, 0);
                else if (hazard())        set_exp(i, 0, 0, 0, 1, 1);
                else                      set_exp(i, 1, 1, 0, 1, 0);
            end
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                owed[i] = 0; dleft[i] = 0; draining[i] = 0; hlt[i] = 0; cnt[i] = 0;
            end else if (!hlt[i]) begin
                if (!e_pc[i] && cnt[i] < cmax[i]) cnt[i]++;
                if (draining[i]) begin
                    if (!mem_busy) begin
                        if (dleft[i] == 1) begin hlt[i] = 1; draining[i] = 0; end
                        else dleft[i]--;
                    end
                end else if (owed[i] > 0) begin
                    if (redirect)       owed[i] = 0;
                    else if (!mem_busy) owed[i]--;
                end else begin
                    if (ex_halt) begin draining[i] = 1; dleft[i] = DRAIN_N; end
                    else if (!redirect && !mem_busy && hazard()) owed[i] = lu_n[i] - 1;
                end
            end
        end
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        string p;
        for (int i = 0; i < 2; i++) begin
            p = (i == 0) ? "a." : "b.";
            check({p, "pc_write"},     32'(o_pc[i]),     32'(e_pc[i]));
            check({p, "if_id_write"},  32'(o_ifid[i]),   32'(e_ifid[i]));
            check({p, "if_id_flush"},  32'(o_flush[i]),  32'(e_flush[i]));
            check({p, "id_ex_write"},  32'(o_idex[i]),   32'(e_idex[i]));
            check({p, "id_ex_bubble"}, 32'(o_bub[i]),    32'(e_bub[i]));
            check({p, "halted"},       32'(o_halted[i]), 32'(hlt[i]));
        end
        check("a.stall_count", 32'(sc_a), 32'(cnt[0]));
        check("b.stall_count", 32'(sc_b), 32'(cnt[1]));
    endtask

    // drivers
    task automatic cycle();
        @(negedge clk);
        model_outputs();
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input int rs, input int rt, input bit uses,
                         input bit m2r, input bit rw, input int ert, input bit h,
                         input bit redir, input bit busy);
        rst = r; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = uses;
        ex_mem_to_reg = m2r; ex_reg_write = rw; ex_rt = 5'(ert);
        ex_halt = h; redirect = redir; mem_busy = busy;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            owed[i] = 0; dleft[i] = 0; draining[i] = 0; hlt[i] = 0; cnt[i] = 0;
        end
        #1;
        do_reset();
        do_reset();

        // load-use on rs: one bubble for a, three for b
        drive(0, 5, 0, 0, 1, 1, 5, 0, 0, 0); cycle();
        idle(4);
        check("t1_cnt_a", 32'(sc_a), 32'd1);
        check("t1_cnt_b", 32'(sc_b), 32'd3);

        // load-use on rt, then same without uses_rt
        drive(0, 1, 8, 1, 1, 1, 8, 0, 0, 0); cycle();
        idle(4);
        drive(0, 1, 8, 0, 1, 1, 8, 0, 0, 0); cycle();
        idle(2);

        // register 0 never hazards; redirect kills a load-use
        drive(0, 0, 0, 1, 1, 1, 0, 0, 0, 0); cycle();
        drive(0, 5, 0, 0, 1, 1, 5, 0, 1, 0); cycle();
        idle(2);

        // mem_busy during LU_STALL holds the bubble count
        drive(0, 5, 0, 0, 1, 1, 5, 0, 0, 0); cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 1); cycle();
        end
        idle(4);

        // halt drain with one busy cycle inserted
        do_reset();
        drive(0, 1, 2, 0, 0, 0, 0, 1, 0, 0); cycle();
        idle(1);
        drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 1); cycle();
        idle(1);
        check("t5_not_yet", 32'(o_halted[1]), 32'd0);
        idle(1);
        check("t5_halted", 32'(o_halted[1]), 32'd1);
        idle(5);
        check("t5_stays", 32'(o_halted[0]), 32'd1);

        // counter saturation on the 4-bit instance
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 2, 0, 0, 0, 0, 0, 0, 1); cycle();
        end
        check("t6_sat_b", 32'(sc_b), 32'd15);
        check("t6_cnt_a", 32'(sc_a), 32'd20);

        // reset in the middle of a drain
        drive(0, 1, 2, 0, 0, 0, 0, 1, 0, 0); cycle();
        idle(1);
        do_reset();
        check("t6_rst_halted", 32'(o_halted[0]), 32'd0);
        check("t6_rst_cnt", 32'(sc_a), 32'd0);
        idle(1);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            bit r, h;
            r = ($urandom_range(0, 149) == 0) || (hlt[0] && hlt[1] && $urandom_range(0, 3) == 0);
            h = (owed[0] == 0) && (owed[1] == 0) && ($urandom_range(0, 39) == 0);
            drive(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                  $urandom_range(0, 1) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  h, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS core. Reads the decode-stage register fields and the EX-stage control copies produced by the ID/EX pipeline register. Drives the write-enable, bubble and flush controls of the PC, IF/ID and ID/EX registers. Also sequences the halt drain and keeps a saturating stall-cycle counter.

Parameters:
LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..7)
DRAIN_CYCLES, 3, cycles after halt detection before halted asserts (1..15)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, all state changes on posedge
rst  in  1  reset; one clock; reset is synchronous and active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_to_reg  in  1  EX-stage mem_to_reg copy (load in EX)
ex_reg_write  in  1  EX-stage reg_write copy
ex_rt  in  5  EX-stage instruction bits 20:16 copy
ex_halt  in  1  EX-stage halted_wire copy
redirect  in  1  taken branch or jump resolved in EX
mem_busy  in  1  data memory not ready this cycle
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_write  out  1  ID/EX load enable
id_ex_bubble  out  1  ID/EX loads all-zero controls
halted  out  1  core halted, registered
stall_count  out  CNT_W  stall cycles since reset, saturating

Behaviour:
- States: RUN, LU_STALL, DRAIN, HALTED. Counter bcnt (3b) and dcnt (4b).
- Outputs are combinational from state and inputs, except halted and stall_count, which are registered.
- Reset (sync, rst=1 at posedge): state=RUN, bcnt=0, dcnt=0, halted=0, stall_count=0.
- Default enables with no hazard: pc_write=1, if_id_write=1, id_ex_write=1, flush=0, bubble=0.
- Priority in RUN, highest first: ex_halt > redirect > mem_busy > load-use.
- load_use = ex_mem_to_reg & ex_reg_write & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)). Register 0 never hazards.
- RUN, ex_halt=1:
  - pc_write=0, if_id_flush=1, id_ex_bubble=1.
  - next DRAIN, dcnt=DRAIN_CYCLES-1.
- RUN, redirect=1:
  - pc_write=1 (target), if_id_flush=1, id_ex_bubble=1.
  - Stay RUN.
  - A load-use in the same cycle is ignored, because the ID instruction is killed.
- RUN, mem_busy=1:
  - pc_write=if_id_write=id_ex_write=0 (full freeze).
  - Stay RUN; load-use is re-evaluated when mem_busy drops.
- RUN, load_use:
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If LU_BUBBLES=1, stay RUN (next cycle load is in MEM, no re-detect). Else next LU_STALL, bcnt=LU_BUBBLES-2.
- LU_STALL:
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If bcnt==0, next RUN, else bcnt-1.
  - mem_busy=1 freezes everything (id_ex_write=0, no bubble) and holds bcnt.
  - redirect=1 applies RUN redirect outputs and goes to RUN.
  - ex_halt is not possible here (EX holds bubbles).
- DRAIN:
  - pc_write=0, if_id_flush=1, id_ex_bubble=1.
  - dcnt decrements each cycle unless mem_busy=1 (hold).
  - When dcnt==0 and mem_busy=0, next HALTED, and halted<=1 at that edge.
- HALTED:
  - pc_write=if_id_write=id_ex_write=0.
  - halted=1; only rst exits.
- stall_count:
  - +1 on every cycle with pc_write=0 and state!=HALTED (load-use, freeze, drain).
  - Saturates at all-ones.
- rst mid-operation: takes effect next edge regardless of state; outputs follow RUN defaults from the cycle after.

Test Plan:
1. Load-use, LU_BUBBLES=1: ex_mem_to_reg=1, ex_reg_write=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle; stall_count=1.
2. Load-use, LU_BUBBLES=3, ex_rt=8=id_rt, id_uses_rt=1 -> 3 consecutive bubble cycles, then pc_write=1; stall_count=3. Repeat with id_uses_rt=0 -> no stall.
3. ex_rt=0=id_rs with load in EX -> no stall. Load-use plus redirect in same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1, no LU_STALL.
4. mem_busy=1 for 4 cycles during LU_STALL (bcnt=1) -> all enables 0; bubble count resumes after; total bubbles still LU_BUBBLES.
5. ex_halt=1, DRAIN_CYCLES=3 -> halted=1 exactly 3 edges later, with 1 mem_busy cycle inserted -> 4 edges; stays 1 until rst.
6. Preload stall_count near all-ones via long mem_busy (CNT_W=4, 20 cycles) -> saturates at 15. rst asserted in DRAIN -> state RUN, halted=0, stall_count=0 next cycle.
